// File: rtl/traffic_light_monitor.sv
// Passive checker for a four-way traffic light controller: decodes the observed
// lamps into a phase and flags encoding, conflict, sequence and dwell errors.
module traffic_light_monitor #(
    parameter int unsigned GREEN_CYCLES  = 16,
    parameter int unsigned YELLOW_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] north_light,
    input  logic [2:0] west_light,
    input  logic [2:0] south_light,
    input  logic [2:0] east_light,
    output logic [2:0] phase,
    output logic       phase_valid,
    output logic       err_encoding,
    output logic       err_conflict,
    output logic       err_sequence,
    output logic       err_duration,
    output logic       err_sticky,
    output logic [7:0] rotations
);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [8:0] GREEN_REQ  = 9'(GREEN_CYCLES);
    localparam logic [8:0] YELLOW_REQ = 9'(YELLOW_CYCLES);

    typedef enum logic [2:0] {
        N_G = 3'b000, N_Y = 3'b001, W_G = 3'b010, W_Y = 3'b011,
        S_G = 3'b110, S_Y = 3'b111, E_G = 3'b100, E_Y = 3'b101
    } phase_e;

    // Direction field walks N(00) -> W(01) -> S(11) -> E(10), a Gray sequence.
    function automatic phase_e next_phase(input phase_e p);
        logic [2:0] v;
        v = p;
        if (!v[0]) return phase_e'({v[2:1], 1'b1});
        return phase_e'({v[1], ~v[2], 1'b0});
    endfunction

    phase_e      phase_q, phase_d;
    logic        phase_valid_q, phase_valid_d;
    logic        err_encoding_q, err_encoding_d;
    logic        err_conflict_q, err_conflict_d;
    logic        err_sequence_q, err_sequence_d;
    logic        err_duration_q, err_duration_d;
    logic        err_sticky_q, err_sticky_d;
    logic [7:0]  rotations_q, rotations_d;
    logic [7:0]  dwell_q, dwell_d;
    logic        synced_q, synced_d;

    logic [3:0][2:0] lamp;
    logic            enc_bad;
    logic [2:0]      nonred_cnt;
    logic [1:0]      dir_idx;
    logic            dir_yel;
    logic            legal;
    phase_e          dec_phase;
    logic [8:0]      req_dwell;

    always_comb begin
        lamp       = {east_light, south_light, west_light, north_light};
        enc_bad    = 1'b0;
        nonred_cnt = 3'd0;
        dir_idx    = 2'd0;
        dir_yel    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (lamp[i] != LAMP_RED && lamp[i] != LAMP_YEL && lamp[i] != LAMP_GRN) begin
                enc_bad = 1'b1;
            end else if (lamp[i] != LAMP_RED) begin
                nonred_cnt = nonred_cnt + 3'd1;
                dir_idx    = 2'(i);
                dir_yel    = (lamp[i] == LAMP_YEL);
            end
        end
        legal     = !enc_bad && (nonred_cnt == 3'd1);
        dec_phase = phase_e'({dir_idx[1], dir_idx[1] ^ dir_idx[0], dir_yel});
        req_dwell = phase_q[0] ? YELLOW_REQ : GREEN_REQ;

        phase_d        = phase_q;
        phase_valid_d  = 1'b0;
        err_encoding_d = enc_bad;
        err_conflict_d = !enc_bad && (nonred_cnt >= 3'd2);
        err_sequence_d = 1'b0;
        err_duration_d = 1'b0;
        rotations_d    = rotations_q;
        dwell_d        = dwell_q;
        synced_d       = synced_q;

        if (legal) begin
            phase_valid_d = 1'b1;
            phase_d       = dec_phase;
            if (!synced_q) begin
                synced_d = 1'b1;
                dwell_d  = 8'd1;
            end else if (dec_phase != phase_q) begin
                err_sequence_d = (dec_phase != next_phase(phase_q));
                // Overrun was already reported while dwelling; only underrun here.
                err_duration_d = ({1'b0, dwell_q} < req_dwell);
                if (phase_q == E_Y && dec_phase == N_G && {1'b0, dwell_q} == YELLOW_REQ)
                    rotations_d = rotations_q + 8'd1;
                dwell_d = 8'd1;
            end else begin
                if (dwell_q != 8'hFF) dwell_d = dwell_q + 8'd1;
                err_duration_d = (dwell_q != 8'hFF) && ({1'b0, dwell_d} == req_dwell + 9'd1);
            end
        end else begin
            synced_d = 1'b0;
            dwell_d  = 8'd0;
        end

        err_sticky_d = err_sticky_q | err_encoding_d | err_conflict_d
                     | err_sequence_d | err_duration_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q        <= N_G;
            phase_valid_q  <= 1'b0;
            err_encoding_q <= 1'b0;
            err_conflict_q <= 1'b0;
            err_sequence_q <= 1'b0;
            err_duration_q <= 1'b0;
            err_sticky_q   <= 1'b0;
            rotations_q    <= 8'd0;
            dwell_q        <= 8'd0;
            synced_q       <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            phase_valid_q  <= phase_valid_d;
            err_encoding_q <= err_encoding_d;
            err_conflict_q <= err_conflict_d;
            err_sequence_q <= err_sequence_d;
            err_duration_q <= err_duration_d;
            err_sticky_q   <= err_sticky_d;
            rotations_q    <= rotations_d;
            dwell_q        <= dwell_d;
            synced_q       <= synced_d;
        end
    end

    assign phase        = phase_q;
    assign phase_valid  = phase_valid_q;
    assign err_encoding = err_encoding_q;
    assign err_conflict = err_conflict_q;
    assign err_sequence = err_sequence_q;
    assign err_duration = err_duration_q;
    assign err_sticky   = err_sticky_q;
    assign rotations    = rotations_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: decode table, reference-model scoreboard and
// hand-written multi-cycle scenarios (rotation, dwell, sequence, conflict, reset).
module tb_traffic_light_monitor;

    localparam int G = 16;
    localparam int Y = 4;
    localparam logic [2:0] R = 3'b100, YL = 3'b010, GR = 3'b001;

    logic       clk, reset;
    logic [2:0] north_light, west_light, south_light, east_light;
    logic [2:0] phase;
    logic       phase_valid, err_encoding, err_conflict, err_sequence, err_duration, err_sticky;
    logic [7:0] rotations;

    traffic_light_monitor #(.GREEN_CYCLES(G), .YELLOW_CYCLES(Y)) dut (
        .clk(clk), .reset(reset),
        .north_light(north_light), .west_light(west_light),
        .south_light(south_light), .east_light(east_light),
        .phase(phase), .phase_valid(phase_valid),
        .err_encoding(err_encoding), .err_conflict(err_conflict),
        .err_sequence(err_sequence), .err_duration(err_duration),
        .err_sticky(err_sticky), .rotations(rotations)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] phase;
        logic       valid, enc, conf, seq, dur, sticky;
        logic [7:0] rot;
    } obs_t;

    typedef struct {
        logic [11:0] lamps;  // {n, w, s, e}
        logic [2:0]  phase;
        logic        valid, enc, conf;
    } vec_t;

    obs_t sb_q[$];
    obs_t obs;
    int   n_checks = 0, n_pass = 0;
    int   err_seen;

    // Reference model state
    logic [2:0] m_phase;
    logic       m_valid, m_synced, m_sticky;
    int         m_dwell;
    logic [7:0] m_rot;
    logic [2:0] order [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5};
    logic [2:0] green_of_dir [4] = '{3'd0, 3'd2, 3'd6, 3'd4};

    function automatic logic [2:0] succ(input logic [2:0] p);
        for (int k = 0; k < 8; k++) if (order[k] == p) return order[(k + 1) % 8];
        return 3'd0;
    endfunction

    function automatic logic [11:0] lamps_of(input logic [2:0] p);
        logic [2:0] l;
        logic [11:0] v;
        l = p[0] ? YL : GR;
        v = {R, R, R, R};
        case (p[2:1])
            2'b00: v[11:9] = l;
            2'b01: v[8:6]  = l;
            2'b11: v[5:3]  = l;
            default: v[2:0] = l;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_phase = 3'd0; m_valid = 0; m_synced = 0; m_sticky = 0; m_dwell = 0; m_rot = 8'd0;
    endtask

    function automatic obs_t model_step(input logic [11:0] lv);
        logic [2:0] l [4];
        obs_t e;
        int cnt, req;
        logic bad;
        logic [2:0] dp;
        l[0] = lv[11:9]; l[1] = lv[8:6]; l[2] = lv[5:3]; l[3] = lv[2:0];
        e = '0; bad = 0; cnt = 0; dp = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!(l[i] inside {R, YL, GR})) bad = 1;
            else if (l[i] != R) begin
                cnt++;
                dp = green_of_dir[i] | {2'b00, l[i] == YL};
            end
        end
        e.enc  = bad;
        e.conf = !bad && cnt >= 2;
        if (!bad && cnt == 1) begin
            req = m_phase[0] ? Y : G;
            if (!m_synced) begin
                m_synced = 1; m_dwell = 1;
            end else if (dp != m_phase) begin
                e.seq = (dp != succ(m_phase));
                e.dur = (m_dwell < req);
                if (m_phase == 3'b101 && dp == 3'b000 && m_dwell == Y) m_rot = m_rot + 8'd1;
                m_dwell = 1;
            end else if (m_dwell < 255) begin
                m_dwell++;
                e.dur = (m_dwell == req + 1);
            end
            m_phase = dp; m_valid = 1;
        end else begin
            m_valid = 0; m_synced = 0; m_dwell = 0;
        end
        m_sticky = m_sticky | e.enc | e.conf | e.seq | e.dur;
        e.phase = m_phase; e.valid = m_valid; e.sticky = m_sticky; e.rot = m_rot;
        return e;
    endfunction

    function automatic obs_t sample();
        return {phase, phase_valid, err_encoding, err_conflict, err_sequence,
                err_duration, err_sticky, rotations};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Drive one pattern; expectation goes to the scoreboard, popped after the edge.
    task automatic step(input logic [11:0] lv);
        obs_t exp;
        @(negedge clk);
        {north_light, west_light, south_light, east_light} = lv;
        sb_q.push_back(model_step(lv));
        @(posedge clk);
        #1;
        obs = sample();
        exp = sb_q.pop_front();
        if (obs.enc | obs.conf | obs.seq | obs.dur) err_seen++;
        check("scoreboard", 32'(obs), 32'(exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        {north_light, west_light, south_light, east_light} = {R, R, R, R};
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb_q.delete();
        err_seen = 0;
    endtask

    vec_t tbl [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{{GR, R, R, R},     3'b000, 1, 0, 0};
        tbl[1]  = '{{YL, R, R, R},     3'b001, 1, 0, 0};
        tbl[2]  = '{{R, GR, R, R},     3'b010, 1, 0, 0};
        tbl[3]  = '{{R, YL, R, R},     3'b011, 1, 0, 0};
        tbl[4]  = '{{R, R, GR, R},     3'b110, 1, 0, 0};
        tbl[5]  = '{{R, R, YL, R},     3'b111, 1, 0, 0};
        tbl[6]  = '{{R, R, R, GR},     3'b100, 1, 0, 0};
        tbl[7]  = '{{R, R, R, YL},     3'b101, 1, 0, 0};
        tbl[8]  = '{{R, R, R, R},      3'b000, 0, 0, 0};
        tbl[9]  = '{{GR, R, R, GR},    3'b000, 0, 0, 1};
        tbl[10] = '{{R, R, 3'b011, R}, 3'b000, 0, 1, 0};
        tbl[11] = '{{3'b000, R, R, R}, 3'b000, 0, 1, 0};
        tbl[12] = '{{GR, YL, GR, YL},  3'b000, 0, 0, 1};
        tbl[13] = '{{3'b111, GR, R, GR}, 3'b000, 0, 1, 0};

        reset = 1'b1;
        {north_light, west_light, south_light, east_light} = {R, R, R, R};
        model_reset();
        err_seen = 0;
        #2;
        check("reset_state", 32'(sample()), 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Single-pattern decode table, each from a fresh reset
        for (int t = 0; t < 14; t++) begin
            do_reset();
            step(tbl[t].lamps);
            check($sformatf("table%0d", t),
                  {28'd0, obs.phase, obs.valid},   {28'd0, tbl[t].phase, tbl[t].valid});
            check($sformatf("table%0d_err", t),
                  {29'd0, obs.enc, obs.conf, obs.sticky},
                  {29'd0, tbl[t].enc, tbl[t].conf, tbl[t].enc | tbl[t].conf});
        end

        // Two full legal rotations
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 8; k++)
                repeat (order[k][0] ? Y : G) step(lamps_of(order[k]));
        step(lamps_of(3'b000));
        check("rot_errors", 32'(err_seen), 32'd0);
        check("rot_count", 32'(rotations), 32'd2);

        // Green overrun: pulse after the 17th sample, none at the change
        do_reset();
        repeat (16) step(lamps_of(3'b000));
        check("ovr_early", 32'(err_seen), 32'd0);
        step(lamps_of(3'b000));
        check("ovr_pulse", 32'(obs.dur), 32'd1);
        step(lamps_of(3'b001));
        check("ovr_no_repeat", {30'd0, obs.dur, obs.sticky}, {30'd0, 1'b0, 1'b1});

        // Skipped yellow
        do_reset();
        repeat (16) step(lamps_of(3'b000));
        step(lamps_of(3'b010));
        check("seq_skip", {28'd0, obs.seq, obs.phase}, {28'd0, 1'b1, 3'b010});
        check("seq_skip_dur", 32'(obs.dur), 32'd0);

        // Conflict for three cycles, then resync without a sequence error
        do_reset();
        repeat (5) step(lamps_of(3'b000));
        repeat (3) begin
            step({GR, R, R, GR});
            check("conflict", {30'd0, obs.conf, obs.valid}, {30'd0, 1'b1, 1'b0});
        end
        step(lamps_of(3'b010));
        check("resync", {30'd0, obs.seq, obs.valid}, {30'd0, 1'b0, 1'b1});

        // Single illegal lamp code
        do_reset();
        repeat (3) step(lamps_of(3'b010));
        step({R, GR, 3'b011, R});
        check("encoding", 32'(obs.enc), 32'd1);
        step(lamps_of(3'b010));
        check("encoding_once", 32'(obs.enc), 32'd0);

        // Async reset in the 8th W-G cycle, then resume mid-phase
        do_reset();
        repeat (7) step(lamps_of(3'b010));
        step({GR, R, R, GR});  // make sticky/conflict non-zero before the reset
        @(negedge clk);
        {north_light, west_light, south_light, east_light} = lamps_of(3'b010);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", 32'(sample()), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        sb_q.delete();
        err_seen = 0;
        repeat (8) step(lamps_of(3'b010));
        check("resume_errors", 32'(err_seen), 32'd0);
        check("resume_phase", {28'd0, obs.phase, obs.valid}, {28'd0, 3'b010, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
